// File: rtl/jk_ctrl_pkg.sv
// Shared types for the JK bank arbiter: FSM state and per-bit JK command codes.
package jk_ctrl_pkg;
    typedef enum logic {IDLE = 1'b0, APPLY = 1'b1} state_t;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;
endpackage

// File: rtl/jk_ff_bank.sv
// WIDTH-bit bank of JK flip-flops; updates only when en is high, async clear on rst.
module jk_ff_bank
    import jk_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar
);
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;

    always_comb begin
        w_next = r_q;
        for (int i = 0; i < WIDTH; i++) begin
            case ({j[i], k[i]})
                JK_HOLD: w_next[i] = r_q[i];
                JK_RST:  w_next[i] = 1'b0;
                JK_SET:  w_next[i] = 1'b1;
                JK_TGL:  w_next[i] = ~r_q[i];
                default: w_next[i] = r_q[i];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     r_q <= '0;
        else if (en) r_q <= w_next;
    end

    assign q     = r_q;
    assign q_bar = ~r_q;
endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin sharing of one JK flip-flop bank between NREQ requesters.
// IDLE picks and latches a command, APPLY drives it into the bank for one cycle.
module jk_bank_arbiter
    import jk_ctrl_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] j_vec,
    input  logic [NREQ*WIDTH-1:0] k_vec,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic [WIDTH-1:0]      q,
    output logic [WIDTH-1:0]      q_bar
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NREQ - 1);

    state_t            r_state;
    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W-1:0]  r_win;
    logic [WIDTH-1:0]  r_cmd_j;
    logic [WIDTH-1:0]  r_cmd_k;
    logic [NREQ-1:0]   r_gnt;
    logic              r_busy;

    logic              w_found;
    logic [PTR_W-1:0]  w_win;
    logic [PTR_W-1:0]  w_idx;
    logic [WIDTH-1:0]  w_j;
    logic [WIDTH-1:0]  w_k;

    // Walk upward from ptr with explicit wrap so non-power-of-2 NREQ never
    // visits an index past NREQ-1.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = r_ptr;
        for (int off = 0; off < NREQ; off++) begin
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
            w_idx = (w_idx == LAST) ? '0 : w_idx + 1'b1;
        end
    end

    always_comb begin
        w_j = '0;
        w_k = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == PTR_W'(i)) begin
                w_j = j_vec[i*WIDTH +: WIDTH];
                w_k = k_vec[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_cmd_j <= '0;
            r_cmd_k <= '0;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_cmd_j <= w_j;
                        r_cmd_k <= w_k;
                        r_win   <= w_win;
                        r_gnt   <= NREQ'(1) << w_win;
                        r_busy  <= 1'b1;
                        r_state <= APPLY;
                    end
                end
                APPLY: begin
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_ptr   <= (r_win == LAST) ? '0 : r_win + 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    jk_ff_bank #(.WIDTH(WIDTH)) u_bank (
        .clk   (clk),
        .rst   (rst),
        .en    (r_state == APPLY),
        .j     (r_cmd_j),
        .k     (r_cmd_k),
        .q     (q),
        .q_bar (q_bar)
    );

    assign gnt  = r_gnt;
    assign busy = r_busy;
endmodule
